// File: rtl/latch_loader_pkg.sv
// latch_loader_pkg
//   Shared definitions for the latch loader front end: the load-sequence
//   state encoding and the default timing parameters.
package latch_loader_pkg;

    // Consecutive stable cycles before a debounced input follows its raw input.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    // Number of cycles the latch enable is held high.
    localparam int DEFAULT_EN_WIDTH        = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_PULSE    = 3'd2,
        ST_HOLD     = 3'd3,
        ST_WAIT_REL = 3'd4
    } loader_state_t;

endpackage

// File: rtl/debounce.sv
// debounce
//   Filters one raw, bouncy board input. The registered output q follows raw
//   only after raw has differed from q for DEBOUNCE_CYCLES consecutive cycles;
//   any shorter excursion is discarded.
//
// Ports
//   CLK  in  clock, rising edge
//   R    in  synchronous reset, active-low (q and counter clear to 0)
//   raw  in  raw input
//   q    out debounced, registered output
module debounce
    import latch_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic CLK,
    input  logic R,
    input  logic raw,
    output logic q
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;

    // The counter "reaching" DEBOUNCE_CYCLES is detected one step early, so
    // the update to q lands on the same edge the count would hit the limit.
    always_comb begin
        cnt_d = '0;
        q_d   = q_q;
        if (raw != q_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                q_d   = raw;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!R) begin
            cnt_q <= '0;
            q_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/latch_loader.sv
// latch_loader
//   Drives the D/EN pins of a downstream D-latch from a bouncy data switch and
//   a bouncy load button. Each clean press captures the debounced switch onto
//   D, waits one setup cycle, raises EN for EN_WIDTH cycles, waits one hold
//   cycle, then blocks further loads until the button is released.
//
// Ports
//   CLK   in  clock, rising edge
//   R     in  synchronous reset, active-low
//   SW    in  raw data switch
//   BTN   in  raw load button, active-high
//   D     out data to the latch (changes only on capture or reset)
//   EN    out latch enable pulse (registered)
//   BUSY  out load sequence in progress (registered)
module latch_loader
    import latch_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int EN_WIDTH        = DEFAULT_EN_WIDTH
) (
    input  logic CLK,
    input  logic R,
    input  logic SW,
    input  logic BTN,
    output logic D,
    output logic EN,
    output logic BUSY
);

    localparam int PCNT_W = $clog2(EN_WIDTH + 1);

    logic sw_db;
    logic btn_db;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_db (
        .CLK (CLK),
        .R   (R),
        .raw (SW),
        .q   (sw_db)
    );

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_db (
        .CLK (CLK),
        .R   (R),
        .raw (BTN),
        .q   (btn_db)
    );

    loader_state_t     state_q;
    logic [PCNT_W-1:0] pcnt_q;
    logic              d_q;
    logic              en_q;
    logic              busy_q;

    // EN and BUSY are registered alongside the state so they always equal
    // (state == PULSE) and (state != IDLE) without any input-to-output path.
    always_ff @(posedge CLK) begin
        if (!R) begin
            state_q <= ST_IDLE;
            pcnt_q  <= '0;
            d_q     <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_db) begin
                        d_q     <= sw_db;
                        state_q <= ST_SETUP;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_PULSE;
                    en_q    <= 1'b1;
                    pcnt_q  <= '0;
                end
                ST_PULSE: begin
                    if (pcnt_q == PCNT_W'(EN_WIDTH - 1)) begin
                        state_q <= ST_HOLD;
                        en_q    <= 1'b0;
                        pcnt_q  <= '0;
                    end else begin
                        pcnt_q  <= pcnt_q + PCNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    state_q <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    // Holding the button never re-triggers; a release is required.
                    if (!btn_db) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    pcnt_q  <= '0;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign D    = d_q;
    assign EN   = en_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_latch_loader.sv
module tb_latch_loader;

    logic CLK = 1'b0;
    logic R   = 1'b0;
    logic SW  = 1'b0;
    logic BTN = 1'b0;
    logic D, EN, BUSY;

    // Behavioural stand-in for the downstream D-latch, sampled each cycle.
    logic latch_q = 1'b0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    latch_loader #(
        .DEBOUNCE_CYCLES(4),
        .EN_WIDTH       (2)
    ) dut (
        .CLK  (CLK),
        .R    (R),
        .SW   (SW),
        .BTN  (BTN),
        .D    (D),
        .EN   (EN),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d want %0d", tag, $time, act, exp);
        end
    endtask

    // Advance one rising edge and sample in the middle of the low phase.
    task automatic cycle();
        @(posedge CLK);
        @(negedge CLK);
        if (EN) latch_q = D;
    endtask

    initial begin
        // Reset held with both raw inputs high.
        R = 1'b0; SW = 1'b1; BTN = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            cycle();
            chk("rst_D", D, 0);
            chk("rst_EN", EN, 0);
            chk("rst_BUSY", BUSY, 0);
        end

        // Out of reset: button still high for 3 cycles (short of debounce), then low.
        R = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            if (n == 4) BTN = 1'b0;
            cycle();
            chk("post_rst_EN", EN, 0);
            chk("post_rst_BUSY", BUSY, 0);
        end

        // Load high: SW debounced to 1 already; press and hold.
        BTN = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            cycle();
            chk("ldh_EN", EN, (n == 6 || n == 7) ? 1 : 0);
            chk("ldh_D", D, (n >= 5) ? 1 : 0);
            chk("ldh_BUSY", BUSY, (n >= 5) ? 1 : 0);
            chk("ldh_Q", latch_q, (n >= 6) ? 1 : 0);
        end
        BTN = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            cycle();
            chk("ldh_rel_BUSY", BUSY, (n < 5) ? 1 : 0);
            chk("ldh_rel_EN", EN, 0);
        end

        // Bounce rejection: toggle every cycle for 6 cycles, then low.
        for (int n = 1; n <= 12; n++) begin
            BTN = (n <= 6) ? ((n % 2 == 1) ? 1'b1 : 1'b0) : 1'b0;
            cycle();
            chk("bnc_EN", EN, 0);
            chk("bnc_BUSY", BUSY, 0);
        end

        // Held button, SW drops while EN is high: one pulse, D unchanged.
        BTN = 1'b1;
        pulses = 0;
        for (int n = 1; n <= 20; n++) begin
            cycle();
            if (EN) pulses++;
            chk("hold_EN", EN, (n == 6 || n == 7) ? 1 : 0);
            chk("hold_D", D, 1);
            chk("hold_BUSY", BUSY, (n >= 5) ? 1 : 0);
            if (n == 6) SW = 1'b0;
        end
        chk("hold_pulse_cycles", pulses, 2);
        BTN = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            cycle();
            chk("hold_rel_BUSY", BUSY, (n < 5) ? 1 : 0);
            chk("hold_rel_D", D, 1);
        end

        // Load low: SW debounced to 0 by now; press.
        BTN = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            cycle();
            chk("ldl_EN", EN, (n == 6 || n == 7) ? 1 : 0);
            chk("ldl_D", D, (n >= 5) ? 0 : 1);
            chk("ldl_Q", latch_q, (n >= 6) ? 0 : 1);
        end
        BTN = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            cycle();
            chk("ldl_rel_BUSY", BUSY, (n < 5) ? 1 : 0);
        end

        // Reset during PULSE: debounce SW=1, press, reset on first EN cycle.
        SW = 1'b1;
        for (int n = 1; n <= 6; n++) cycle();
        BTN = 1'b1;
        for (int n = 1; n <= 6; n++) cycle();
        chk("rp_EN_before", EN, 1);
        chk("rp_D_before", D, 1);
        R = 1'b0;
        cycle();
        chk("rp_EN", EN, 0);
        chk("rp_D", D, 0);
        chk("rp_BUSY", BUSY, 0);
        // Button still held: must debounce again from 0 before re-triggering.
        R = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            cycle();
            chk("rp_redb_BUSY", BUSY, (n >= 5) ? 1 : 0);
            chk("rp_redb_EN", EN, (n == 6 || n == 7) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: got timeout want finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
